clk_ratio_detector: RTL
=======================

// Module: clk_ratio_detector
// PURPOSE
//  Measures an incoming divided clock (sclk) against the fast reference clock iclk.
//  Reports sclk period and high time in iclk cycles, and flags lock when the period is stable.
//  Sits on the receive side of the clock divider; used for divisor recovery and self-check.
// PARAMETERS
//  MAX_RATIO   64  largest measurable sclk period in iclk cycles; longer periods raise timeout
//  LOCK_COUNT  4   consecutive identical period measurements required to assert locked
//  SYNC_STAGES 2   synchronizer flops on sclk (>=2)
//  (local) CW = $clog2(MAX_RATIO+1)
// PORTS
//  iclk       in   1   reference clock; all logic on posedge
//  rst        in   1   reset, asynchronous, active-high
//  sclk       in   1   clock under measurement, asynchronous to iclk
//  enable     in   1   1 = measure; 0 = return to IDLE
//  period     out  CW  last measured rise-to-rise interval, iclk cycles
//  high_time  out  CW  last measured rise-to-fall interval, iclk cycles
//  valid      out  1   one-cycle pulse when period/high_time update
//  locked     out  1   period stable for LOCK_COUNT measurements
//  timeout    out  1   no sclk rise within MAX_RATIO cycles
// BEHAVIOUR
//  Reset: sync flops=0, cnt=0, run=0, state=IDLE; all outputs 0.
//  Sync: sclk passes SYNC_STAGES flops, then one edge-detect flop.
//   rise = s & ~s_d; fall = ~s & s_d.
//  cnt: on rise, cnt<=1; otherwise cnt<=cnt+1, saturating at MAX_RATIO.
//   On a fall, hi_cap<=cnt.
//   Example: rises 6 cycles apart give cnt==6 at the second rise.
//  FSM:
//   IDLE: enable=0. cnt, run, locked, timeout cleared; period/high_time hold.
//    enable=1 -> WAIT_EDGE.
//   WAIT_EDGE: ignore falls. First rise starts cnt, no valid -> MEASURE.
//   MEASURE/LOCKED, on rise (registered, visible next cycle):
//    - valid=1; period<=cnt; high_time<=hi_cap; timeout<=0.
//    - run<= (cnt==period && run!=0) ? min(run+1,LOCK_COUNT) : 1.
//    - locked<= (new run==LOCK_COUNT); state follows locked.
//  Timeout: cnt==MAX_RATIO and no rise in the same cycle.
//   -> timeout<=1 (held), locked<=0, run<=0, -> WAIT_EDGE; period/high_time hold.
//   A rise coincident with cnt==MAX_RATIO is a legal measurement; no timeout.
//  enable falling: next cycle -> IDLE; an in-flight rise is dropped, no valid.
//  Latency: sclk rise -> valid is about SYNC_STAGES+2 iclk cycles; constant, so periods are exact.
//  Supported ratios: 2..MAX_RATIO. sclk high and low must each span >=1 iclk posedge.
//  Odd ratios from a dual-edge divider: period is exact; high_time is floor or ceil, constant for a fixed phase.
//  Lock is judged on period only. Mismatch in LOCKED drops locked in the same cycle valid pulses.
//  rst asserted mid-operation: immediate async clear to reset values.
// TESTING
//  1 sclk=iclk/4 (2 hi/2 lo), enable=1 -> valid every 4 cycles, period=4, high_time=2; locked on 4th valid.
//  2 sclk=iclk/3 from dual-edge divider -> period=3 each valid, high_time in {1,2} constant; locked on 4th.
//  3 locked at ratio 4, switch to ratio 6 -> first period=6 valid drops locked; relock on 4th valid at 6.
//  4 stop sclk low after lock -> timeout=1, locked=0 at cnt==64; restart -> timeout clears on first valid.
//  5 ratio 64 (=MAX_RATIO) -> period=64, timeout stays 0; ratio 65 -> timeout, no valid.
//  6 rst pulse mid-measure -> outputs 0 immediately; enable=0 -> IDLE, locked=0; re-enable relocks.

Source files
------------

// File: rtl/clk_ratio_detector.sv
// Measures the period and high time of an asynchronous divided clock (sclk) in
// reference-clock (iclk) cycles, and flags lock once the period is stable.
module clk_ratio_detector #(
  parameter int MAX_RATIO   = 64,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(MAX_RATIO + 1)
) (
  input  logic          iclk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          enable,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          locked,
  output logic          timeout
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_RATIO);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          hi_cap_q, hi_cap_d;
  logic [RW-1:0]          run_q, run_d;
  logic [CW-1:0]          period_q, period_d;
  logic [CW-1:0]          high_time_q, high_time_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;

  logic          s, rise, fall;
  logic [CW-1:0] cnt_inc;
  logic [RW-1:0] run_nx;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sclk};
    s      = sync_q[SYNC_STAGES-1];
    s_d_d  = s;
    rise   = s & ~s_d_q;
    fall   = ~s & s_d_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = fall ? cnt_q : hi_cap_q;
    run_d       = run_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    run_nx      = '0;
    cnt_inc     = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + 1'b1;

    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      run_d     = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_EDGE;
        // The first rise only opens the measurement window.
        WAIT_EDGE: begin
          if (rise) begin
            cnt_d   = CW'(1);
            state_d = MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            cnt_d       = CW'(1);
            valid_d     = 1'b1;
            period_d    = cnt_q;
            high_time_d = hi_cap_q;
            timeout_d   = 1'b0;
            if (cnt_q == period_q && run_q != '0)
              run_nx = (run_q == LOCK_RUN) ? LOCK_RUN : run_q + 1'b1;
            else
              run_nx = RW'(1);
            run_d    = run_nx;
            locked_d = (run_nx == LOCK_RUN);
            state_d  = (run_nx == LOCK_RUN) ? LOCKED : MEASURE;
          end else if (cnt_q == MAX_CNT) begin
            // A rise in the saturating cycle still counts as a measurement.
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = '0;
            cnt_d     = '0;
            state_d   = WAIT_EDGE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      s_d_q       <= 1'b0;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      run_q       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      s_d_q       <= s_d_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      run_q       <= run_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
